// File: rtl/rf_port_arbiter_if.sv
// Requester and register-file signal bundle for rf_port_arbiter.
// The arbiter takes the slave modport; requesters and the register file sit on the master side.
interface rf_port_arbiter_if;
  logic [1:0]  req_valid;
  logic [9:0]  req_rd1;
  logic [9:0]  req_rd2;
  logic [9:0]  req_wr;
  logic [15:0] req_data;
  logic [5:0]  req_en;
  logic [1:0]  req_gnt;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic [7:0]  resp_out1;
  logic [7:0]  resp_out2;
  logic [4:0]  rf_read_reg1;
  logic [4:0]  rf_read_reg2;
  logic [4:0]  rf_write_reg;
  logic [7:0]  rf_data;
  logic [2:0]  rf_valid_bits;
  logic [7:0]  rf_out1;
  logic [7:0]  rf_out2;
  logic        rf_output_valid;

  modport slave (
    input  req_valid, req_rd1, req_rd2, req_wr, req_data, req_en,
    output req_gnt, req_done, req_err, resp_out1, resp_out2,
    output rf_read_reg1, rf_read_reg2, rf_write_reg, rf_data, rf_valid_bits,
    input  rf_out1, rf_out2, rf_output_valid
  );

  modport master (
    output req_valid, req_rd1, req_rd2, req_wr, req_data, req_en,
    input  req_gnt, req_done, req_err, resp_out1, resp_out2,
    input  rf_read_reg1, rf_read_reg2, rf_write_reg, rf_data, rf_valid_bits,
    output rf_out1, rf_out2, rf_output_valid
  );
endinterface

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing one register file between the core (req 0) and loader (req 1).
// Each grant runs IDLE -> ISSUE -> WAIT -> DONE; all outputs are registered.
module rf_port_arbiter #(
  parameter int TIMEOUT          = 15,
  parameter int ZERO_REG_PROTECT = 1
) (
  input  logic             clk,
  input  logic             reset,
  rf_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [4:0] rd1;
    logic [4:0] rd2;
    logic [4:0] wr;
    logic [7:0] data;
    logic [2:0] en;
  } bundle_t;

  state_t      state;
  logic        ptr;      // favoured requester when both are pending
  logic        g;
  logic [2:0]  lat_en;
  logic [CW-1:0] cnt;

  logic        sel;
  bundle_t     nxt;
  logic [2:0]  nxt_vb;
  logic        rd_req;
  logic        time_up;

  always_comb begin
    sel      = bus.req_valid[1] & (~bus.req_valid[0] | ptr);
    nxt.rd1  = sel ? bus.req_rd1[9:5]   : bus.req_rd1[4:0];
    nxt.rd2  = sel ? bus.req_rd2[9:5]   : bus.req_rd2[4:0];
    nxt.wr   = sel ? bus.req_wr[9:5]    : bus.req_wr[4:0];
    nxt.data = sel ? bus.req_data[15:8] : bus.req_data[7:0];
    nxt.en   = sel ? bus.req_en[5:3]    : bus.req_en[2:0];
    nxt_vb   = nxt.en;
    if (ZERO_REG_PROTECT != 0 && nxt.wr == 5'd0) nxt_vb[0] = 1'b0;
    rd_req   = |lat_en[2:1];
    time_up  = (cnt == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      ptr               <= 1'b0;
      g                 <= 1'b0;
      lat_en            <= '0;
      cnt               <= '0;
      bus.req_gnt       <= '0;
      bus.req_done      <= '0;
      bus.req_err       <= '0;
      bus.resp_out1     <= '0;
      bus.resp_out2     <= '0;
      bus.rf_read_reg1  <= '0;
      bus.rf_read_reg2  <= '0;
      bus.rf_write_reg  <= '0;
      bus.rf_data       <= '0;
      bus.rf_valid_bits <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req_valid) begin
          g                 <= sel;
          lat_en            <= nxt.en;
          bus.req_gnt       <= sel ? 2'b10 : 2'b01;
          // Address/data registers double as the latched bundle for ISSUE.
          bus.rf_read_reg1  <= nxt.rd1;
          bus.rf_read_reg2  <= nxt.rd2;
          bus.rf_write_reg  <= nxt.wr;
          bus.rf_data       <= nxt.data;
          bus.rf_valid_bits <= nxt_vb;
          state             <= ISSUE;
        end
        ISSUE: begin
          bus.rf_valid_bits <= '0;
          cnt               <= '0;
          state             <= WAIT;
        end
        WAIT: begin
          if (!rd_req || bus.rf_output_valid || time_up) begin
            bus.req_done  <= bus.req_gnt;
            bus.req_err   <= (rd_req && !bus.rf_output_valid) ? bus.req_gnt : 2'b00;
            bus.resp_out1 <= (rd_req && bus.rf_output_valid && lat_en[2]) ? bus.rf_out1 : 8'h00;
            bus.resp_out2 <= (rd_req && bus.rf_output_valid && lat_en[1]) ? bus.rf_out2 : 8'h00;
            state         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus.req_done  <= '0;
          bus.req_err   <= '0;
          bus.resp_out1 <= '0;
          bus.resp_out2 <= '0;
          bus.req_gnt   <= '0;
          ptr           <= ~g;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a 1-cycle register-file model.
module tb_rf_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic mute;
  logic [7:0] mem [32];
  int vectors = 0;
  int miscompares = 0;
  int cyc;

  rf_port_arbiter_if bus();

  rf_port_arbiter #(.TIMEOUT(15), .ZERO_REG_PROTECT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register-file model: writes on bit0, read data one cycle after a read enable.
  always @(posedge clk) begin
    if (bus.rf_valid_bits[0]) mem[bus.rf_write_reg] <= bus.rf_data;
    bus.rf_output_valid <= (|bus.rf_valid_bits[2:1]) && !mute;
    bus.rf_out1 <= mem[bus.rf_read_reg1];
    bus.rf_out2 <= mem[bus.rf_read_reg2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (!reset && bus.req_gnt == 2'b11) chk("gnt_onehot", bus.req_gnt, 2'b01);

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.req_done == 2'b00 && n < budget);
    if (bus.req_done == 2'b00) chk("done_timeout_bound", {30'd0, bus.req_done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[1] = 8'h2D;
    mem[2] = 8'hEC;
    mute = 1'b0;
    reset = 1'b1;
    bus.req_valid = '0; bus.req_rd1 = '0; bus.req_rd2 = '0;
    bus.req_wr = '0; bus.req_data = '0; bus.req_en = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_gnt", bus.req_gnt, 2'b00);
    chk("rst_done", bus.req_done, 2'b00);
    chk("rst_vb", bus.rf_valid_bits, 3'b000);
    chk("rst_resp1", bus.resp_out1, 8'h00);

    // req0 write r5 = 0x2D
    bus.req_wr[4:0] = 5'd5; bus.req_data[7:0] = 8'h2D; bus.req_en[2:0] = 3'b001;
    bus.req_valid = 2'b01;
    tick();
    chk("wr_issue_wreg", bus.rf_write_reg, 5'd5);
    chk("wr_issue_data", bus.rf_data, 8'h2D);
    chk("wr_issue_vb", bus.rf_valid_bits, 3'b001);
    chk("wr_issue_gnt", bus.req_gnt, 2'b01);
    tick();
    chk("wr_wait_vb", bus.rf_valid_bits, 3'b000);
    chk("wr_wait_done", bus.req_done, 2'b00);
    tick();
    chk("wr_done", bus.req_done, 2'b01);
    chk("wr_err", bus.req_err, 2'b00);
    chk("wr_mem5", mem[5], 8'h2D);
    bus.req_valid = 2'b00;
    tick();
    chk("wr_idle_done", bus.req_done, 2'b00);
    chk("wr_idle_gnt", bus.req_gnt, 2'b00);

    // req0 dual read r1/r2
    bus.req_rd1[4:0] = 5'd1; bus.req_rd2[4:0] = 5'd2; bus.req_en[2:0] = 3'b110;
    bus.req_valid = 2'b01;
    tick();
    chk("rd_issue_vb", bus.rf_valid_bits, 3'b110);
    chk("rd_issue_rd1", bus.rf_read_reg1, 5'd1);
    chk("rd_issue_rd2", bus.rf_read_reg2, 5'd2);
    tick(); tick();
    chk("rd_done", bus.req_done, 2'b01);
    chk("rd_resp1", bus.resp_out1, 8'h2D);
    chk("rd_resp2", bus.resp_out2, 8'hEC);
    chk("rd_err", bus.req_err, 2'b00);
    bus.req_valid = 2'b00;
    tick();
    chk("rd_idle_resp1", bus.resp_out1, 8'h00);

    // req1 write to r0 is suppressed but still completes
    bus.req_wr[9:5] = 5'd0; bus.req_data[15:8] = 8'h7F; bus.req_en[5:3] = 3'b001;
    bus.req_valid = 2'b10;
    tick();
    chk("z_issue_gnt", bus.req_gnt, 2'b10);
    chk("z_issue_vb", bus.rf_valid_bits, 3'b000);
    tick(); tick();
    chk("z_done", bus.req_done, 2'b10);
    chk("z_err", bus.req_err, 2'b00);
    chk("z_mem0", mem[0], 8'h00);
    bus.req_valid = 2'b00;
    tick();

    // Fairness after reset: 0, 1, then 0 again
    reset = 1'b1; tick(); reset = 1'b0;
    bus.req_wr = {5'd4, 5'd3}; bus.req_data = {8'h22, 8'h11}; bus.req_en = {3'b001, 3'b001};
    bus.req_valid = 2'b11;
    tick();
    chk("rr1_gnt", bus.req_gnt, 2'b01);
    tick(); tick();
    chk("rr1_done", bus.req_done, 2'b01);
    bus.req_valid = 2'b10;
    tick();
    chk("rr1_idle_gnt", bus.req_gnt, 2'b00);
    tick();
    chk("rr2_gnt", bus.req_gnt, 2'b10);
    tick(); tick();
    chk("rr2_done", bus.req_done, 2'b10);
    bus.req_valid = 2'b00;
    tick();
    bus.req_valid = 2'b11;
    tick();
    chk("rr3_gnt", bus.req_gnt, 2'b01);
    tick(); tick();
    chk("rr3_done", bus.req_done, 2'b01);
    bus.req_valid = 2'b10;
    tick(); tick();
    chk("rr4_gnt", bus.req_gnt, 2'b10);
    tick(); tick();
    chk("rr4_done", bus.req_done, 2'b10);
    chk("rr_mem3", mem[3], 8'h11);
    chk("rr_mem4", mem[4], 8'h22);
    bus.req_valid = 2'b00;
    tick();

    // Timeout: read with no rf_output_valid
    mute = 1'b1;
    bus.req_rd1[4:0] = 5'd1; bus.req_en[2:0] = 3'b100;
    bus.req_valid = 2'b01;
    tick();
    chk("to_issue_vb", bus.rf_valid_bits, 3'b100);
    wait_done(40, cyc);
    chk("to_cycles", cyc, 16);
    chk("to_done", bus.req_done, 2'b01);
    chk("to_err", bus.req_err, 2'b01);
    chk("to_resp1", bus.resp_out1, 8'h00);
    bus.req_valid = 2'b00;
    tick();
    chk("to_idle_err", bus.req_err, 2'b00);

    // Reset while in WAIT
    bus.req_en[2:0] = 3'b110;
    bus.req_valid = 2'b01;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid = 2'b00;
    chk("rw_gnt", bus.req_gnt, 2'b00);
    chk("rw_done", bus.req_done, 2'b00);
    chk("rw_vb", bus.rf_valid_bits, 3'b000);
    chk("rw_resp2", bus.resp_out2, 8'h00);
    tick();
    chk("rw_nodone", bus.req_done, 2'b00);
    mute = 1'b0;
    bus.req_en = {3'b001, 3'b001};
    bus.req_valid = 2'b11;
    tick();
    chk("rw_first_gnt", bus.req_gnt, 2'b01);
    tick(); tick();
    chk("rw_first_done", bus.req_done, 2'b01);
    bus.req_valid = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the single 8-bit register file (two read ports, one write port, 3-bit valid_bits enable vector) between two requesters.
- Requester 0 is the multicycle processor core; requester 1 is the loader/debug port that preloads and inspects registers.
- Round-robin arbiter plus a per-transaction sequencer: issues one register-file access per grant, waits for rf_output_valid, and returns read data with a done pulse.
- Sits between the requesters and reg_file; it is the only driver of the register-file input ports.

Parameters:
- TIMEOUT, 15: max WAIT cycles for rf_output_valid before the transaction completes with error; counter width is clog2(TIMEOUT+1).
- ZERO_REG_PROTECT, 1: when 1, writes addressed to register 0 are suppressed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i: requester i has a transaction pending; held until its done pulse.
- req_rd1  in  10  requester i read address 1 at [5i+4:5i].
- req_rd2  in  10  requester i read address 2 at [5i+4:5i].
- req_wr  in  10  requester i write address at [5i+4:5i].
- req_data  in  16  requester i write data at [8i+7:8i].
- req_en  in  6  requester i enables at [3i+2:3i]: bit2 read1, bit1 read2, bit0 write.
- req_gnt  out  2  one-hot, grant held from ISSUE through DONE.
- req_done  out  2  one-cycle completion pulse for the granted requester.
- req_err  out  2  asserted with req_done on timeout.
- resp_out1  out  8  read data 1; valid while req_done is high.
- resp_out2  out  8  read data 2; valid while req_done is high.
- rf_read_reg1  out  5  register-file read address 1.
- rf_read_reg2  out  5  register-file read address 2.
- rf_write_reg  out  5  register-file write address.
- rf_data  out  8  register-file write data.
- rf_valid_bits  out  3  register-file enables; nonzero only in ISSUE.
- rf_out1  in  8  register-file read data 1.
- rf_out2  in  8  register-file read data 2.
- rf_output_valid  in  1  register-file read data valid.

Behaviour:
- Reset (synchronous, any state): FSM to IDLE.
  - All outputs 0; priority pointer = 0 (requester 0 favoured).
  - Latched bundle and timeout counter cleared. No done pulse for an aborted transaction.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - rf_valid_bits=000.
  - If any req_valid bit is set: select requester g.
    - Only one requesting: that one.
    - Both requesting: the one indicated by the pointer.
  - Latch g's address, data and enable fields; set req_gnt[g]; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive rf_read_reg1/2, rf_write_reg and rf_data from the latch.
  - rf_valid_bits = latched enables, with bit0 forced 0 when ZERO_REG_PROTECT=1 and write address = 0.
  - Next state is WAIT; clear the counter.
- WAIT:
  - rf_valid_bits=000.
  - If enables[2:1]==00 (write-only or no-op): go to DONE next cycle without waiting.
  - Otherwise: on rf_output_valid=1, capture rf_out1 if bit2 else 0, and rf_out2 if bit1 else 0; go to DONE.
  - Otherwise increment the counter. When it reaches TIMEOUT: set err, resp=0, go to DONE.
- DONE (1 cycle):
  - req_done[g]=1; req_err[g]=err; resp_out1/2 valid.
  - Pointer set to the other requester; go to IDLE; gnt cleared on exit.
- Requester rules:
  - A requester deasserts req_valid in the cycle after its done pulse.
  - req_valid is not sampled in DONE, so a new request is sampled in IDLE at the earliest.
  - Fields must be stable from assertion until done; they are latched at IDLE, and later changes are ignored.
- Latency, read with a 1-cycle register file: req_valid sampled in IDLE at edge N; ISSUE in cycle N+1; capture at N+2; done high in cycle N+3.
- Back-to-back throughput is one transaction per 4 cycles.
- Fairness: alternating priority guarantees a waiting requester is served within one foreign transaction.
- No-op (en=000) completes normally with resp=0 and err=0.
- An rf_output_valid pulse outside WAIT is ignored.

Test Plan:
- Reset, then req0 en=001, wr=5, data=0x2D → in ISSUE: rf_write_reg=5, rf_data=0x2D, rf_valid_bits=001; req_done=01 three cycles after sampling; req_err=00.
- req0 en=110, rd1=1, rd2=2, register-file model returns 0x2D/0xEC with 1-cycle latency → resp_out1=0x2D, resp_out2=0xEC coincident with req_done[0].
- Both req_valid high after reset → requester 0 served first, then requester 1. A second simultaneous round starts with requester 0 again (the pointer toggles after each grant); req_gnt is never 11.
- req1 en=001, wr=0, data=0x7F → rf_valid_bits=000 in ISSUE; req_done[1] still pulses; err=0.
- req0 en=100 with rf_output_valid held 0 → after 15 WAIT cycles: req_done[0]=1, req_err[0]=1, resp_out1=0x00.
- Reset asserted in WAIT → next cycle: IDLE, all outputs 0, no done pulse. With both requesting afterwards, requester 0 is granted first.
